regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port between two requesters.
//  - Pipeline writeback: always has priority.
//  - Multi-cycle mult/div unit (MDU): its results are buffered in a small FIFO.
//  Keeps a 32-entry pending scoreboard of MDU destinations so the hazard unit can stall dependent instructions.
//  Sits between the WB stage, the MDU and regfile (en_write/wadd/data).
// PARAMETERS
//  DEPTH         2   MDU result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  4   cycles head FIFO entry may wait before stall_req asserts
//  AW            5   register address width
//  DW            32  data width
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   synchronous active-high reset
//  wb_en       in   1   pipeline writeback request
//  wb_addr     in   AW  pipeline destination register
//  wb_data     in   DW  pipeline writeback data
//  mdu_valid   in   1   MDU result valid
//  mdu_addr    in   AW  MDU destination register
//  mdu_data    in   DW  MDU result
//  mdu_ready   out  1   FIFO can accept (= !full)
//  issue_valid in   1   MDU op issued this cycle; mark issue_addr pending
//  issue_addr  in   AW  destination of issued MDU op
//  chk_addr1   in   AW  hazard lookup (rs)
//  chk_addr2   in   AW  hazard lookup (rt)
//  busy1       out  1   chk_addr1 pending (combinational from scoreboard)
//  busy2       out  1   chk_addr2 pending
//  stall_req   out  1   registered; asks pipeline to free the port next cycle
//  rf_we       out  1   to regfile en_write
//  rf_wadd     out  AW  to regfile wadd
//  rf_wdata    out  DW  to regfile data
// BEHAVIOUR
//  Reset:
//   - FIFO empty; scoreboard all 0; starve counter 0; stall_req 0.
//   - With wb_en=0: rf_we=0, rf_wadd=0, rf_wdata=0. mdu_ready=1.
//  Requests:
//   - A pipeline write is "real" iff wb_en && wb_addr!=0.
//   - wb_en with wb_addr==0 counts as no request and frees the port.
//  Write-port mux (combinational, zero latency):
//   - Real pipeline write: drive it.
//   - Else, FIFO non-empty: drive FIFO head and pop at the edge.
//   - Else: rf_we=0, rf_wadd=0, rf_wdata=0.
//  FIFO:
//   - Push on mdu_valid && mdu_ready.
//   - mdu_valid while full: the result is held by the MDU, never dropped.
//   - MDU results with addr 0 are accepted, then discarded at pop with rf_we=0.
//   - Push and pop in the same cycle are both legal, including when full.
//   - When full, mdu_ready=0 even if a pop happens this cycle (no combinational ready path).
//   - Pointers wrap modulo DEPTH.
//  Scoreboard:
//   - Set bit issue_addr on issue_valid (addr 0 ignored).
//   - Clear bit rf_wadd when a FIFO entry is written.
//   - Same reg set and cleared in one cycle: set wins.
//   - busy1 and busy2 are 0 for addr 0.
//  Starvation:
//   - Counter increments each cycle the FIFO is non-empty and not popped; clears on pop or when empty.
//   - stall_req<=1 when the counter reaches STARVE_LIMIT-1 and no pop occurs.
//   - stall_req<=0 after the cycle that pops.
//   - The pipeline still wins if it writes during stall_req; stall_req stays high.
//  Reset mid-operation: all FIFO contents and pending bits discarded next edge.
// STRUCTURE
//  Shared package / header:
//   - REG_ZERO=5'd0, AW/DW defaults, NUM_REGS=32.
//  Sub-module wb_result_fifo:
//   - DEPTH x (AW+DW) synchronous FIFO; outputs full, empty, head.
//  Top level holds:
//   - Mux, scoreboard vector, starve counter.
// TESTING
//  1 Reset, then idle: rf_we=0, mdu_ready=1, stall_req=0, busy1=busy2=0.
//  2 issue r8; 3 cycles later mdu (r8,0x1234) with wb_en=0 -> rf_we=1, wadd=8, data=0x1234 next cycle; busy on r8 drops after.
//  3 wb_en=1 (r3,0xAA) continuous; one MDU entry (r9) queued -> stall_req=1 at cycle 4.
//    Then drop wb_en -> r9 written, stall_req=0 next cycle.
//  4 Fill FIFO (r4, r5) during wb_en=1 -> mdu_ready=0; third result held.
//    Release wb_en -> r4, r5 written in order; third accepted once not full.
//  5 Same cycle: issue r7 and retire FIFO entry r7 -> busy(r7)=1 after the edge.
//    Also wb_en=1 to r0 while FIFO non-empty -> FIFO entry written.
//  6 rst asserted with 2 entries queued and r6 pending -> next cycle empty, busy(r6)=0, rf_we=0.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle between WB stage / MDU / hazard unit (master) and the write arbiter (slave).
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          mdu_valid;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;
    logic          mdu_ready;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic [AW-1:0] chk_addr1;
    logic [AW-1:0] chk_addr2;
    logic          busy1;
    logic          busy2;
    logic          stall_req;
    logic          rf_we;
    logic [AW-1:0] rf_wadd;
    logic [DW-1:0] rf_wdata;

    modport master (
        output wb_en, wb_addr, wb_data,
        output mdu_valid, mdu_addr, mdu_data,
        output issue_valid, issue_addr, chk_addr1, chk_addr2,
        input  mdu_ready, busy1, busy2, stall_req,
        input  rf_we, rf_wadd, rf_wdata
    );

    modport slave (
        input  wb_en, wb_addr, wb_data,
        input  mdu_valid, mdu_addr, mdu_data,
        input  issue_valid, issue_addr, chk_addr1, chk_addr2,
        output mdu_ready, busy1, busy2, stall_req,
        output rf_we, rf_wadd, rf_wdata
    );

endinterface

// File: rtl/regfile_write_arbiter_fifo.sv
// MDU result FIFO: DEPTH x W synchronous, head visible combinationally (zero read latency).
// Caller gates push with !full and pop with !empty; full holds off the MDU.
module wb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) wr_d = wr_q + 1'b1;
        if (pop_i)  rd_d = rd_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port: WB stage first, buffered MDU results otherwise; tracks pending MDU dests.
// Mux is zero latency; MDU is held off by mdu_ready=!full, long waits raise a registered stall_req.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_arbiter_if.slave bus
);

    localparam int NR = 2 ** AW;
    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] LIM_M1 = CW'(STARVE_LIMIT - 1);

    logic          full, empty, push, pop, real_wb, fifo_wr;
    logic [AW+DW-1:0] head;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [NR-1:0] pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall_q, stall_d;

    assign real_wb   = bus.wb_en && (bus.wb_addr != AW'(REG_ZERO));
    assign push      = bus.mdu_valid && !full;
    assign pop       = !real_wb && !empty;
    assign head_addr = head[AW+DW-1:DW];
    assign head_data = head[DW-1:0];
    // A popped entry aimed at r0 is consumed without touching the regfile.
    assign fifo_wr   = pop && (head_addr != AW'(REG_ZERO));

    wb_result_fifo #(
        .DEPTH(DEPTH),
        .W    (AW + DW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .din_i  ({bus.mdu_addr, bus.mdu_data}),
        .pop_i  (pop),
        .full_o (full),
        .empty_o(empty),
        .head_o (head)
    );

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_wadd  = '0;
        bus.rf_wdata = '0;
        if (real_wb) begin
            bus.rf_we    = 1'b1;
            bus.rf_wadd  = bus.wb_addr;
            bus.rf_wdata = bus.wb_data;
        end else if (fifo_wr) begin
            bus.rf_we    = 1'b1;
            bus.rf_wadd  = head_addr;
            bus.rf_wdata = head_data;
        end
    end

    // Clear before set so a same-cycle reissue of the retiring register stays pending.
    always_comb begin
        pend_d = pend_q;
        if (fifo_wr) pend_d[head_addr] = 1'b0;
        if (bus.issue_valid && (bus.issue_addr != AW'(REG_ZERO))) pend_d[bus.issue_addr] = 1'b1;
    end

    always_comb begin
        cnt_d   = cnt_q;
        stall_d = stall_q;
        if (empty || pop)        cnt_d = '0;
        else if (cnt_q != LIM_M1) cnt_d = cnt_q + 1'b1;
        if (pop)                                 stall_d = 1'b0;
        else if (!empty && (cnt_d == LIM_M1))    stall_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign bus.mdu_ready = !full;
    assign bus.stall_req = stall_q;
    assign bus.busy1     = (bus.chk_addr1 != AW'(REG_ZERO)) && pend_q[bus.chk_addr1];
    assign bus.busy2     = (bus.chk_addr2 != AW'(REG_ZERO)) && pend_q[bus.chk_addr2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter: per-feature tasks plus a scoreboard of MDU writes.
module tb_regfile_write_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.AW(5), .DW(32)) bus ();

    regfile_write_arbiter #(
        .DEPTH(2), .STARVE_LIMIT(4), .AW(5), .DW(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Scoreboard: accepted MDU results (non-r0) must reach the port in order when the WB stage is idle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.rf_we === 1'b1 && !(bus.wb_en === 1'b1 && bus.wb_addr != 5'd0)) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got wadd=%0d data=%h exp=no write", bus.rf_wadd, bus.rf_wdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.rf_wadd !== e.a || bus.rf_wdata !== e.d) begin
                        bad++;
                        $display("FAIL sb_write got=%0d/%h exp=%0d/%h", bus.rf_wadd, bus.rf_wdata, e.a, e.d);
                    end
                end
            end
            if (bus.mdu_valid === 1'b1 && bus.mdu_ready === 1'b1 && bus.mdu_addr != 5'd0)
                exp_q.push_back('{a: bus.mdu_addr, d: bus.mdu_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_en = 1'b0;       bus.wb_addr = '0;    bus.wb_data = '0;
        bus.mdu_valid = 1'b0;   bus.mdu_addr = '0;   bus.mdu_data = '0;
        bus.issue_valid = 1'b0; bus.issue_addr = '0;
        bus.chk_addr1 = '0;     bus.chk_addr2 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.chk_addr1 = 5'd8;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b0)     begin bad++; $display("FAIL reset_rf_we got=%b exp=0", bus.rf_we); end
        total++; if (bus.rf_wadd !== 5'd0)   begin bad++; $display("FAIL reset_wadd got=%0d exp=0", bus.rf_wadd); end
        total++; if (bus.rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.rf_wdata); end
        total++; if (bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.mdu_ready); end
        total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
        total++; if (bus.busy1 !== 1'b0)     begin bad++; $display("FAIL reset_busy1 got=%b exp=0", bus.busy1); end
        total++; if (bus.busy2 !== 1'b0)     begin bad++; $display("FAIL reset_busy2 got=%b exp=0", bus.busy2); end
    endtask

    task automatic test_mdu_write();
        tick();
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd8; bus.chk_addr1 = 5'd8;
        tick();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.busy1 !== 1'b1) begin bad++; $display("FAIL mdu_busy_set got=%b exp=1", bus.busy1); end
        repeat (2) tick();
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd8; bus.mdu_data = 32'h1234;
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL mdu_no_early got=%b exp=0", bus.rf_we); end
        tick();
        bus.mdu_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wadd !== 5'd8 || bus.rf_wdata !== 32'h1234) begin
            bad++; $display("FAIL mdu_write got=%b/%0d/%h exp=1/8/1234", bus.rf_we, bus.rf_wadd, bus.rf_wdata);
        end
        total++; if (bus.busy1 !== 1'b1) begin bad++; $display("FAIL mdu_busy_hold got=%b exp=1", bus.busy1); end
        tick();
        @(negedge clk);
        total++; if (bus.busy1 !== 1'b0) begin bad++; $display("FAIL mdu_busy_clr got=%b exp=0", bus.busy1); end
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL mdu_idle got=%b exp=0", bus.rf_we); end
    endtask

    task automatic test_starve();
        tick();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hAA;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd9; bus.mdu_data = 32'h9999;
        @(negedge clk);
        total++; if (bus.rf_wadd !== 5'd3 || bus.rf_wdata !== 32'hAA) begin
            bad++; $display("FAIL starve_wb got=%0d/%h exp=3/aa", bus.rf_wadd, bus.rf_wdata);
        end
        tick();
        bus.mdu_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++; if (bus.stall_req !== (i >= 4)) begin
                bad++; $display("FAIL starve_stall_c%0d got=%b exp=%b", i, bus.stall_req, (i >= 4));
            end
            total++; if (bus.rf_we !== 1'b1 || bus.rf_wadd !== 5'd3) begin
                bad++; $display("FAIL starve_wb_wins_c%0d got=%b/%0d exp=1/3", i, bus.rf_we, bus.rf_wadd);
            end
            tick();
        end
        bus.wb_en = 1'b0;
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wadd !== 5'd9) begin
            bad++; $display("FAIL starve_release got=%b/%0d exp=1/9", bus.rf_we, bus.rf_wadd);
        end
        tick();
        @(negedge clk);
        total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL starve_clear got=%b exp=0", bus.stall_req); end
    endtask

    task automatic test_fill();
        tick();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hAA;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd4; bus.mdu_data = 32'h44;
        tick();
        bus.mdu_addr = 5'd5; bus.mdu_data = 32'h55;
        tick();
        bus.mdu_addr = 5'd10; bus.mdu_data = 32'hA0A0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (bus.mdu_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_c%0d got=%b exp=0", i, bus.mdu_ready); end
            tick();
        end
        bus.wb_en = 1'b0;
        @(negedge clk);
        total++; if (bus.rf_wadd !== 5'd4) begin bad++; $display("FAIL fill_first got=%0d exp=4", bus.rf_wadd); end
        total++; if (bus.mdu_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_pop got=%b exp=0", bus.mdu_ready); end
        tick();
        @(negedge clk);
        total++; if (bus.rf_wadd !== 5'd5) begin bad++; $display("FAIL fill_second got=%0d exp=5", bus.rf_wadd); end
        total++; if (bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_back got=%b exp=1", bus.mdu_ready); end
        tick();
        bus.mdu_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.rf_wadd !== 5'd10 || bus.rf_wdata !== 32'hA0A0) begin
            bad++; $display("FAIL fill_third got=%0d/%h exp=10/a0a0", bus.rf_wadd, bus.rf_wdata);
        end
        tick();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b0 || exp_q.size() != 0) begin
            bad++; $display("FAIL fill_drain got we=%b left=%0d exp=0/0", bus.rf_we, exp_q.size());
        end
    endtask

    task automatic test_same_cycle();
        tick();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hAA;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd7; bus.mdu_data = 32'h77;
        tick();
        bus.mdu_valid = 1'b0;
        bus.wb_addr = 5'd0; bus.wb_data = 32'hDEAD;
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd7; bus.chk_addr1 = 5'd7;
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b1 || bus.rf_wadd !== 5'd7 || bus.rf_wdata !== 32'h77) begin
            bad++; $display("FAIL same_r0_frees got=%b/%0d/%h exp=1/7/77", bus.rf_we, bus.rf_wadd, bus.rf_wdata);
        end
        tick();
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd0; bus.wb_en = 1'b0;
        @(negedge clk);
        total++; if (bus.busy1 !== 1'b1) begin bad++; $display("FAIL same_set_wins got=%b exp=1", bus.busy1); end
        tick();
        bus.issue_valid = 1'b0;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd0; bus.mdu_data = 32'h55;
        @(negedge clk);
        total++; if (bus.busy2 !== 1'b0) begin bad++; $display("FAIL same_busy_r0 got=%b exp=0", bus.busy2); end
        tick();
        bus.mdu_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b0 || bus.rf_wadd !== 5'd0 || bus.rf_wdata !== 32'd0) begin
            bad++; $display("FAIL same_r0_discard got=%b/%0d/%h exp=0/0/0", bus.rf_we, bus.rf_wadd, bus.rf_wdata);
        end
        tick();
        @(negedge clk);
        total++; if (bus.mdu_ready !== 1'b1 || bus.rf_we !== 1'b0) begin
            bad++; $display("FAIL same_r0_empty got=%b/%b exp=1/0", bus.mdu_ready, bus.rf_we);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hAA;
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd6; bus.chk_addr1 = 5'd6;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd11; bus.mdu_data = 32'hB1;
        tick();
        bus.issue_valid = 1'b0;
        bus.mdu_addr = 5'd12; bus.mdu_data = 32'hB2;
        tick();
        bus.mdu_valid = 1'b0;
        @(negedge clk);
        total++; if (bus.busy1 !== 1'b1 || bus.mdu_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_setup got=%b/%b exp=1/0", bus.busy1, bus.mdu_ready);
        end
        tick();
        rst = 1'b1; bus.wb_en = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b0)     begin bad++; $display("FAIL rstmid_we got=%b exp=0", bus.rf_we); end
        total++; if (bus.mdu_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", bus.mdu_ready); end
        total++; if (bus.busy1 !== 1'b0)     begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy1); end
        total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall_req); end
        tick();
        @(negedge clk);
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL rstmid_empty got=%b exp=0", bus.rf_we); end
    endtask

    initial begin
        test_reset();
        test_mdu_write();
        test_starve();
        test_fill();
        test_same_cycle();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
